// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: flush > freeze > load, with valid-bit bubble tracking.
// Optional forwarding source fields are enabled by defining ID_EXE_FWD_EN.
module id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic              imm_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [3:0]        status_in,
`ifdef ID_EXE_FWD_EN
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic              two_src_in,
  output logic [REG_AW-1:0] src1_out,
  output logic [REG_AW-1:0] src2_out,
  output logic              two_src_out,
`endif
  output logic              valid_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm24_out,
  output logic              imm_out,
  output logic [3:0]        exe_cmd_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              wb_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [REG_AW-1:0] dest_out,
  output logic [3:0]        status_out,
  output logic              mem_type_out
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm24;
    logic              imm;
    logic [3:0]        exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              b;
    logic              s;
    logic [REG_AW-1:0] dest;
    logic [3:0]        status;
    logic              mem_type;
`ifdef ID_EXE_FWD_EN
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              two_src;
`endif
  } id_exe_t;

  id_exe_t pipe_d, pipe_q;

  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else if (!freeze) begin
      pipe_d.valid         = valid_in;
      pipe_d.pc            = pc_in;
      pipe_d.val_rn        = val_rn_in;
      pipe_d.val_rm        = val_rm_in;
      pipe_d.shift_operand = shift_operand_in;
      pipe_d.signed_imm24  = signed_imm24_in;
      pipe_d.imm           = imm_in;
      pipe_d.exe_cmd       = exe_cmd_in;
      pipe_d.dest          = dest_in;
      pipe_d.status        = status_in;
`ifdef ID_EXE_FWD_EN
      pipe_d.src1          = src1_in;
      pipe_d.src2          = src2_in;
      pipe_d.two_src       = two_src_in;
`endif
      // A bubble must never write back, touch memory or redirect fetch.
      pipe_d.mem_r_en      = valid_in & mem_r_en_in;
      pipe_d.mem_w_en      = valid_in & mem_w_en_in;
      pipe_d.wb_en         = valid_in & wb_en_in;
      pipe_d.b             = valid_in & b_in;
      pipe_d.s             = valid_in & s_in;
      pipe_d.mem_type      = valid_in & (mem_r_en_in | mem_w_en_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign valid_out         = pipe_q.valid;
  assign pc_out            = pipe_q.pc;
  assign val_rn_out        = pipe_q.val_rn;
  assign val_rm_out        = pipe_q.val_rm;
  assign shift_operand_out = pipe_q.shift_operand;
  assign signed_imm24_out  = pipe_q.signed_imm24;
  assign imm_out           = pipe_q.imm;
  assign exe_cmd_out       = pipe_q.exe_cmd;
  assign mem_r_en_out      = pipe_q.mem_r_en;
  assign mem_w_en_out      = pipe_q.mem_w_en;
  assign wb_en_out         = pipe_q.wb_en;
  assign b_out             = pipe_q.b;
  assign s_out             = pipe_q.s;
  assign dest_out          = pipe_q.dest;
  assign status_out        = pipe_q.status;
  assign mem_type_out      = pipe_q.mem_type;
`ifdef ID_EXE_FWD_EN
  assign src1_out          = pipe_q.src1;
  assign src2_out          = pipe_q.src2;
  assign two_src_out       = pipe_q.two_src;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Bench for id_exe_stage_reg: per-cycle compare against a rule-level model,
// plus directed literal checks for reset, load, freeze, flush, memory and bubble cases.
module tb_id_exe_stage_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 0, flush = 0, valid_in = 0;
  logic [31:0] pc_in = 0, val_rn_in = 0, val_rm_in = 0;
  logic [11:0] shift_operand_in = 0;
  logic [23:0] signed_imm24_in = 0;
  logic        imm_in = 0, mem_r_en_in = 0, mem_w_en_in = 0, wb_en_in = 0, b_in = 0, s_in = 0;
  logic [3:0]  exe_cmd_in = 0, dest_in = 0, status_in = 0;
  logic        valid_out, imm_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, mem_type_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  exe_cmd_out, dest_out, status_out;
`ifdef ID_EXE_FWD_EN
  logic [3:0]  src1_in = 0, src2_in = 0, src1_out, src2_out;
  logic        two_src_in = 0, two_src_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .imm_in(imm_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
    .dest_in(dest_in), .status_in(status_in),
`ifdef ID_EXE_FWD_EN
    .src1_in(src1_in), .src2_in(src2_in), .two_src_in(two_src_in),
    .src1_out(src1_out), .src2_out(src2_out), .two_src_out(two_src_out),
`endif
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .imm_out(imm_out), .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out),
    .dest_out(dest_out), .status_out(status_out), .mem_type_out(mem_type_out)
  );

  typedef struct packed {
    logic valid; logic [31:0] pc, rn, rm; logic [11:0] shop; logic [23:0] imm24;
    logic imm; logic [3:0] cmd; logic mr, mw, wb, b, s; logic [3:0] dest, status;
    logic mt;
`ifdef ID_EXE_FWD_EN
    logic [3:0] src1, src2; logic two_src;
`endif
  } rec_t;

  rec_t m, act;

  // What EXE must see after an edge that loads the current ID contents.
  function automatic rec_t loaded();
    rec_t r;
    r = '{valid: valid_in, pc: pc_in, rn: val_rn_in, rm: val_rm_in, shop: shift_operand_in,
          imm24: signed_imm24_in, imm: imm_in, cmd: exe_cmd_in, mr: mem_r_en_in,
          mw: mem_w_en_in, wb: wb_en_in, b: b_in, s: s_in, dest: dest_in,
          status: status_in, mt: mem_r_en_in | mem_w_en_in
`ifdef ID_EXE_FWD_EN
          , src1: src1_in, src2: src2_in, two_src: two_src_in
`endif
         };
    if (!valid_in) begin
      r.mr = 0; r.mw = 0; r.wb = 0; r.b = 0; r.s = 0; r.mt = 0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       m <= '0;
    else if (flush)   m <= '0;
    else if (!freeze) m <= loaded();
  end

  always_comb begin
    act = '{valid: valid_out, pc: pc_out, rn: val_rn_out, rm: val_rm_out,
            shop: shift_operand_out, imm24: signed_imm24_out, imm: imm_out,
            cmd: exe_cmd_out, mr: mem_r_en_out, mw: mem_w_en_out, wb: wb_en_out,
            b: b_out, s: s_out, dest: dest_out, status: status_out, mt: mem_type_out
`ifdef ID_EXE_FWD_EN
            , src1: src1_out, src2: src2_out, two_src: two_src_out
`endif
           };
  end

  always @(negedge clk) begin
    checks++;
    if (act !== m) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act, m);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Inputs change 1ns after the falling edge; literal checks run there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; shift_operand_in = 0;
    signed_imm24_in = 0; imm_in = 0; exe_cmd_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    wb_en_in = 0; b_in = 0; s_in = 0; dest_in = 0; status_in = 0;
`ifdef ID_EXE_FWD_EN
    src1_in = 0; src2_in = 0; two_src_in = 0;
`endif
  endtask

  initial begin
    #21 rst_n = 1;
    step();
    // Reset with all inputs high, asserted mid-cycle
    valid_in = 1; pc_in = '1; val_rn_in = '1; val_rm_in = '1; shift_operand_in = '1;
    signed_imm24_in = '1; imm_in = 1; exe_cmd_in = '1; mem_r_en_in = 1; mem_w_en_in = 1;
    wb_en_in = 1; b_in = 1; s_in = 1; dest_in = '1; status_in = '1;
`ifdef ID_EXE_FWD_EN
    src1_in = '1; src2_in = '1; two_src_in = 1;
`endif
    step();
    chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_wb", {31'd0, wb_en_out}, 32'd0);
    chk("rst_mem_type", {31'd0, mem_type_out}, 32'd0);
    chk("rst_rm", val_rm_out, 32'd0);
    step();
    rst_n = 1;
    idle();

    // Load
    valid_in = 1; pc_in = 32'h10; shift_operand_in = 12'h0A3; exe_cmd_in = 4'h4; wb_en_in = 1;
    step();
    chk("ld_valid", {31'd0, valid_out}, 32'd1);
    chk("ld_pc", pc_out, 32'h10);
    chk("ld_shop", {20'd0, shift_operand_out}, 32'h0A3);
    chk("ld_cmd", {28'd0, exe_cmd_out}, 32'h4);
    chk("ld_wb", {31'd0, wb_en_out}, 32'd1);
    chk("ld_mem_type", {31'd0, mem_type_out}, 32'd0);

    // Freeze for 3 edges
    val_rm_in = 32'hDEAD_BEEF;
    step();
    chk("frz_load", val_rm_out, 32'hDEAD_BEEF);
    val_rm_in = 32'h1234_5678; freeze = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_hold", val_rm_out, 32'hDEAD_BEEF);
    end
    freeze = 0;
    step();
    chk("frz_release", val_rm_out, 32'h1234_5678);

    // Flush beats freeze
    chk("fl_pre_wb", {31'd0, wb_en_out}, 32'd1);
    freeze = 1; flush = 1;
    step();
    chk("fl_valid", {31'd0, valid_out}, 32'd0);
    chk("fl_wb", {31'd0, wb_en_out}, 32'd0);
    chk("fl_rm", val_rm_out, 32'd0);
    chk("fl_pc", pc_out, 32'd0);
    freeze = 0; flush = 0; idle();

    // Memory instructions
    valid_in = 1; mem_w_en_in = 1; shift_operand_in = 12'hFFC;
    step();
    chk("mem_type_st", {31'd0, mem_type_out}, 32'd1);
    chk("mem_shop", {20'd0, shift_operand_out}, 32'hFFC);
    mem_r_en_in = 1;
    step();
    chk("mem_type_both", {31'd0, mem_type_out}, 32'd1);
    chk("mem_both_rw", {30'd0, mem_r_en_out, mem_w_en_out}, 32'd3);

    // Bubble
    idle(); wb_en_in = 1; b_in = 1; shift_operand_in = 12'h5A5;
    step();
    chk("bub_valid", {31'd0, valid_out}, 32'd0);
    chk("bub_wb", {31'd0, wb_en_out}, 32'd0);
    chk("bub_b", {31'd0, b_out}, 32'd0);
    chk("bub_shop", {20'd0, shift_operand_out}, 32'h5A5);

`ifdef ID_EXE_FWD_EN
    idle(); valid_in = 1; src1_in = 4'h5;
    step();
    chk("fwd_src1", {28'd0, src1_out}, 32'h5);
    flush = 1;
    step();
    chk("fwd_src1_flush", {28'd0, src1_out}, 32'h0);
    flush = 0;
`endif

    // Mixed traffic, checked by the per-cycle model compare
    for (int i = 0; i < 60; i++) begin
      valid_in = 1'($urandom); pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
      shift_operand_in = 12'($urandom); signed_imm24_in = 24'($urandom); imm_in = 1'($urandom);
      exe_cmd_in = 4'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
      wb_en_in = 1'($urandom); b_in = 1'($urandom); s_in = 1'($urandom);
      dest_in = 4'($urandom); status_in = 4'($urandom);
`ifdef ID_EXE_FWD_EN
      src1_in = 4'($urandom); src2_in = 4'($urandom); two_src_in = 1'($urandom);
`endif
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      step();
    end
    freeze = 0; flush = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
